// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous word RAM between the
// instruction-fetch (if_*) and data (dm_*) ports of the CPU. It grants the
// ports round-robin and runs one RAM access at a time. Each access returns a
// one-cycle valid pulse with its data.
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   if_req/if_addr             fetch request, held until if_valid
//   if_rdata/if_valid          fetch response (one-cycle pulse)
//   dm_req/dm_we/dm_addr/dm_wdata  data request, held until dm_valid
//   dm_rdata/dm_valid          data response (one-cycle pulse, reads and writes)
//   mem_en/mem_we/mem_addr/mem_wdata  RAM access strobe and write payload
//   mem_rdata                  RAM read data, MEM_LAT edges after mem_en is sampled
//
// Optional build macro MEM_ARB_PERF_EN adds the wait_cnt and acc_cnt
// saturating performance counters.
module mem_port_arbiter #(
  parameter int unsigned AW      = 9,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [31:0]   dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   wait_cnt,
  output logic [31:0]   acc_cnt
`endif
);

  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          last_dm;   // last (and current) grant: 1=DM, 0=IF
  logic [CW-1:0] wcnt;
  logic          grant_go_c;
  logic          grant_dm_c;

  // Byte-offset and high address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0],
                              dm_addr[31:AW+2], dm_addr[1:0]};

  // Grant decision: from IDLE the port other than last_grant wins a tie;
  // from RESP only the other port may be granted, because the served port
  // still presents its old request.
  always_comb begin
    grant_go_c = 1'b0;
    grant_dm_c = 1'b0;
    case (state)
      IDLE: begin
        grant_go_c = if_req | dm_req;
        grant_dm_c = dm_req & (~if_req | ~last_dm);
      end
      RESP: begin
        grant_go_c = last_dm ? if_req : dm_req;
        grant_dm_c = ~last_dm;
      end
      default: ;
    endcase
  end

  // Access sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_dm   <= 1'b0;
      wcnt      <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (grant_go_c) begin
            state    <= ISSUE;
            last_dm  <= grant_dm_c;
            mem_en   <= 1'b1;
            mem_we   <= grant_dm_c & dm_we;
            mem_addr <= grant_dm_c ? dm_addr[AW+1:2] : if_addr[AW+1:2];
            if (grant_dm_c) mem_wdata <= dm_wdata;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          wcnt   <= CW'(MEM_LAT - 1);
          state  <= WAIT;
        end
        WAIT: begin
          if (wcnt == '0) begin
            // Capture is harmless for writes; the response data is don't-care.
            state <= RESP;
            if (last_dm) begin
              dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
          end else begin
            wcnt <= wcnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // A port waits when it requests and is not the port currently being served.
  logic        if_wait_c;
  logic        dm_wait_c;
  logic [32:0] wait_sum_c;

  assign if_wait_c  = if_req & ((state == IDLE) | last_dm);
  assign dm_wait_c  = dm_req & ((state == IDLE) | ~last_dm);
  assign wait_sum_c = {1'b0, wait_cnt} + 33'(if_wait_c) + 33'(dm_wait_c);

  // Saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      acc_cnt  <= '0;
    end else begin
      wait_cnt <= wait_sum_c[32] ? 32'hFFFF_FFFF : wait_sum_c[31:0];
      if (state == RESP && acc_cnt != 32'hFFFF_FFFF) acc_cnt <= acc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 (u1)
// driven from a vector table plus arbitration/reset sequences, and one
// instance with MEM_LAT=3 (u3) for the long-latency and reset-in-WAIT cases.
module tb_mem_port_arbiter;

  logic clk;
  logic rst1, rst3;

  logic        if_req1, dm_req1, dm_we1;
  logic [31:0] if_addr1, dm_addr1, dm_wdata1;
  logic [31:0] if_rdata1, dm_rdata1, mem_wdata1, mem_rdata1;
  logic        if_valid1, dm_valid1, mem_en1, mem_we1;
  logic [8:0]  mem_addr1;

  logic        if_req3, dm_req3, dm_we3;
  logic [31:0] if_addr3, dm_addr3, dm_wdata3;
  logic [31:0] if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
  logic        if_valid3, dm_valid3, mem_en3, mem_we3;
  logic [8:0]  mem_addr3;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] wait_cnt1, acc_cnt1, wait_cnt3, acc_cnt3;
`endif

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(9), .DW(32), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_valid(if_valid1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_valid(dm_valid1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
`ifdef MEM_ARB_PERF_EN
    , .wait_cnt(wait_cnt1), .acc_cnt(acc_cnt1)
`endif
  );

  mem_port_arbiter #(.AW(9), .DW(32), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst3),
    .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_valid(if_valid3),
    .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
    .dm_rdata(dm_rdata3), .dm_valid(dm_valid3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
`ifdef MEM_ARB_PERF_EN
    , .wait_cnt(wait_cnt3), .acc_cnt(acc_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model, latency 1: read data only present in the cycle after the access.
  logic [31:0] ram1 [512];
  logic [31:0] rd1;
  always @(posedge clk) begin
    if (mem_en1 && mem_we1) ram1[mem_addr1] <= mem_wdata1;
    rd1 <= (mem_en1 && !mem_we1) ? ram1[mem_addr1] : 32'h0;
  end
  assign mem_rdata1 = rd1;

  // RAM model, latency 3: content is an address-derived pattern.
  logic [31:0] p3a, p3b, p3c;
  always @(posedge clk) begin
    p3a <= (mem_en3 && !mem_we3) ? (32'hC0DE_0000 | 32'(mem_addr3)) : 32'h0;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign mem_rdata3 = p3c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        exp_dm;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [8:0]  exp_maddr;
  } vec_t;

  vec_t vecs[10];

  // Single-port transaction on u1 with full timing and strobe checks.
  task automatic run_vec(input vec_t v, input string tag);
    int n = 0;
    int en_cnt = 0;
    int we_cnt = 0;
    int bad = 0;
    bit got = 0;
    @(negedge clk);
    if_req1 = v.if_req; if_addr1 = v.if_addr;
    dm_req1 = v.dm_req; dm_we1 = v.dm_we; dm_addr1 = v.dm_addr; dm_wdata1 = v.dm_wdata;
    while (!got && n < 16) begin
      @(posedge clk); #1; n++;
      if (mem_en1) begin
        en_cnt++;
        if (n == 1) begin
          chk({tag, " mem_addr"}, 32'(mem_addr1), 32'(v.exp_maddr));
          if (v.dm_req && v.dm_we) chk({tag, " mem_wdata"}, mem_wdata1, v.dm_wdata);
        end
      end
      if (mem_we1) begin
        we_cnt++;
        if (!mem_en1 || n != 1) bad++;
      end
      if (if_valid1 && dm_valid1) bad++;
      if (if_valid1 || dm_valid1) got = 1;
    end
    chk({tag, " latency"}, 32'(n), 32'd3);
    chk({tag, " port"}, 32'(dm_valid1), 32'(v.exp_dm));
    if (v.chk_data) chk({tag, " rdata"}, v.exp_dm ? dm_rdata1 : if_rdata1, v.exp_data);
    chk({tag, " en count"}, 32'(en_cnt), 32'd1);
    chk({tag, " we count"}, 32'(we_cnt), 32'(v.dm_req & v.dm_we));
    chk({tag, " strobe rules"}, 32'(bad), 32'd0);
    @(negedge clk);
    if_req1 = 1'b0; dm_req1 = 1'b0; dm_we1 = 1'b0;
    @(posedge clk); #1;
    chk({tag, " valid pulse width"}, 32'({if_valid1, dm_valid1, mem_en1}), 32'd0);
  endtask

  // Single IF read on u3, expected n edges to valid.
  task automatic run3(input string tag, input logic [31:0] addr);
    int n = 0;
    int en_cnt = 0;
    @(negedge clk);
    if_req3 = 1'b1; if_addr3 = addr;
    while (!if_valid3 && n < 20) begin
      @(posedge clk); #1; n++;
      if (mem_en3) en_cnt++;
    end
    chk({tag, " latency"}, 32'(n), 32'd5);
    chk({tag, " rdata"}, if_rdata3, 32'hC0DE_0000 | 32'(addr[10:2]));
    chk({tag, " en count"}, 32'(en_cnt), 32'd1);
    @(negedge clk);
    if_req3 = 1'b0;
  endtask

  logic unused_tb;
  assign unused_tb = ^{dm_rdata3, mem_wdata3, dm_valid3
`ifdef MEM_ARB_PERF_EN
                       , wait_cnt1, wait_cnt3, acc_cnt3
`endif
                      };

  initial begin
    int n;
    int k;
    int cnt;
    int both;

    vecs[0] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, 32'h2008_0001, 1'b1, 1'b0, 32'h0,          9'd2};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0010, 32'h1111_2222, 1'b1, 1'b0, 32'h0,          9'd4};
    vecs[2] = '{1'b1, 32'h8,        1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h2008_0001, 9'd2};
    vecs[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 1'b1, 32'h1111_2222, 9'd4};
    vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,          9'd16};
    vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0040, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 9'd16};
    vecs[6] = '{1'b1, 32'h808,      1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h2008_0001, 9'd2};
    vecs[7] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0,          9'd511};
    vecs[8] = '{1'b1, 32'h7FC,      1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h5A5A_5A5A, 9'd511};
    vecs[9] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h1000_0040, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 9'd16};

    rst1 = 1'b1; rst3 = 1'b1;
    if_req1 = 0; if_addr1 = 0; dm_req1 = 0; dm_we1 = 0; dm_addr1 = 0; dm_wdata1 = 0;
    if_req3 = 0; if_addr3 = 0; dm_req3 = 0; dm_we3 = 0; dm_addr3 = 0; dm_wdata3 = 0;

    // Reset values.
    @(posedge clk); #1;
    chk("reset outputs", 32'({mem_en1, mem_we1, if_valid1, dm_valid1}), 32'd0);
    chk("reset mem_addr", 32'(mem_addr1), 32'd0);
    chk("reset rdata", if_rdata1 | dm_rdata1 | mem_wdata1, 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("reset acc_cnt", acc_cnt1, 32'd0);
`endif
    @(negedge clk); rst1 = 1'b0; rst3 = 1'b0;

    // Reset while mem_en is high: outputs fall at once, nothing issues afterwards.
    @(negedge clk); if_req1 = 1'b1; if_addr1 = 32'h8;
    @(posedge clk); #1;
    chk("pre-reset mem_en", 32'(mem_en1), 32'd1);
    #1 rst1 = 1'b1;
    #1 chk("async reset outputs", 32'({mem_en1, mem_we1, if_valid1, dm_valid1}), 32'd0);
    @(negedge clk); if_req1 = 1'b0;
    @(negedge clk); rst1 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (mem_en1 || if_valid1 || dm_valid1) cnt++;
    end
    chk("idle after reset", 32'(cnt), 32'd0);

    // Table of single-port accesses.
    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Request dropped one cycle after being sampled: access still completes.
    @(negedge clk); if_req1 = 1'b1; if_addr1 = 32'h8;
    @(negedge clk); if_req1 = 1'b0;
    n = 1;
    while (!if_valid1 && n < 16) begin @(posedge clk); #1; n++; end
    chk("dropped req latency", 32'(n), 32'd3);
    chk("dropped req rdata", if_rdata1, 32'h2008_0001);

    // Both ports held high after reset: DM first, strict alternation, 3 cycles each.
    @(negedge clk); rst1 = 1'b1;
    @(negedge clk); rst1 = 1'b0;
    if_req1 = 1'b1; if_addr1 = 32'h8;
    dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 32'h10;
    n = 0; k = 0; both = 0;
    while (k < 6 && n < 40) begin
      @(posedge clk); #1; n++;
      if (if_valid1 && dm_valid1) both++;
      if (if_valid1 || dm_valid1) begin
        chk($sformatf("pair%0d port", k), 32'(dm_valid1), 32'((k % 2) == 0));
        chk($sformatf("pair%0d cycle", k), 32'(n), 32'(3 * (k + 1)));
        chk($sformatf("pair%0d rdata", k), dm_valid1 ? dm_rdata1 : if_rdata1,
            ((k % 2) == 0) ? 32'h1111_2222 : 32'h2008_0001);
        k++;
      end
    end
    chk("pair count", 32'(k), 32'd6);
    chk("pair never both valid", 32'(both), 32'd0);
    @(negedge clk); if_req1 = 1'b0; dm_req1 = 1'b0;
    @(posedge clk); #1;
`ifdef MEM_ARB_PERF_EN
    chk("acc_cnt", acc_cnt1, 32'd6);
`endif
    @(posedge clk); #1;
    chk("pair idle", 32'({mem_en1, if_valid1, dm_valid1}), 32'd0);

    // MEM_LAT=3: normal read, then reset during WAIT, then recovery.
    run3("lat3 read", 32'h24);
    @(negedge clk); if_req3 = 1'b1; if_addr3 = 32'h30;
    repeat (3) @(posedge clk);
    #2 rst3 = 1'b1;
    #1 chk("lat3 reset outputs", 32'({mem_en3, if_valid3}), 32'd0);
    @(negedge clk); if_req3 = 1'b0;
    @(negedge clk); rst3 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (mem_en3 || if_valid3) cnt++;
    end
    chk("lat3 discarded access", 32'(cnt), 32'd0);
    run3("lat3 after reset", 32'h7FC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
